// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-load / run controller.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [31:0] PASS_CODE = 32'd1;

endpackage

// File: rtl/prog_loader_bank_addr.sv
// Per-bank write address counter. It saturates at the last location; full_o
// means that location has been written, so any further word must be dropped.
module prog_loader_bank_addr #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              full_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              full_q;

  // Advance on each written word; the top address sets full instead of wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= {ADDR_W{1'b0}};
      full_q <= 1'b0;
    end else if (clr_i) begin
      addr_q <= {ADDR_W{1'b0}};
      full_q <= 1'b0;
    end else if (inc_i && !full_q) begin
      if (addr_q == {ADDR_W{1'b1}}) begin
        full_q <= 1'b1;
      end else begin
        addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      addr_q <= addr_q;
      full_q <= full_q;
    end
  end

  assign addr_o = addr_q;
  assign full_o = full_q;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Streams memory images into N_BANKS banks, then runs the core until a tohost
// store or timeout. Optional trailing-checksum check: PROG_LOADER_CHECKSUM_EN.
module prog_loader_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 10,
  parameter int          N_BANKS     = 2,
  parameter int unsigned TOHOST_ADDR = 32'h3FF,
  parameter int          TIMEOUT_CYC = 100000,
  parameter int          CNT_W       = 32,
  localparam int         BANK_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               LOAD_VALID,
  output logic               LOAD_READY,
  input  logic [DATA_W-1:0]  LOAD_DATA,
  input  logic [BANK_W-1:0]  LOAD_BANK,
  input  logic               LOAD_LAST,
  output logic [N_BANKS-1:0] MEM_WE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [DATA_W-1:0]  MEM_WDATA,
  output logic               CORE_RESET_N,
  input  logic               MON_WE,
  input  logic [ADDR_W-1:0]  MON_ADDR,
  input  logic [DATA_W-1:0]  MON_WDATA,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic               TIMEOUT,
  output logic               LOAD_ERR,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic               CSUM_OK,
`endif
  output logic [DATA_W-1:0]  RESULT,
  output logic [CNT_W-1:0]   CYCLES
);
  import prog_loader_pkg::*;

  state_e             state_q, state_d;
  logic [N_BANKS-1:0] mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               ready_q, ready_d, busy_q, busy_d, crn_q, crn_d;
  logic               done_q, done_d, pass_q, pass_d, tout_q, tout_d, err_q, err_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [31:0]        csum_q, csum_d;
  logic               csum_ok_q, csum_ok_d;

  logic [N_BANKS-1:0] bank_oh_s, bank_inc_s, bank_full_s;
  logic [ADDR_W-1:0]  bank_addr_s [N_BANKS];
  logic [ADDR_W-1:0]  addr_sel_s;
  logic               full_sel_s, bank_ok_s, hs_s, wr_s, drop_s, tohost_s, clr_s;

  // Select the addressed bank's counter; an out-of-range index selects none
  always_comb begin
    bank_oh_s  = '0;
    addr_sel_s = '0;
    full_sel_s = 1'b0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (LOAD_BANK == BANK_W'(i)) begin
        bank_oh_s[i] = 1'b1;
        addr_sel_s   = bank_addr_s[i];
        full_sel_s   = bank_full_s[i];
      end else begin
        bank_oh_s[i] = 1'b0;
      end
    end
  end

  assign bank_ok_s = |bank_oh_s;
  assign hs_s      = (state_q == ST_LOAD) && LOAD_VALID;
`ifdef PROG_LOADER_CHECKSUM_EN
  // The trailing word carries the checksum and is never written
  assign wr_s   = hs_s && !LOAD_LAST && bank_ok_s && !full_sel_s;
  assign drop_s = hs_s && !LOAD_LAST && !(bank_ok_s && !full_sel_s);
`else
  assign wr_s   = hs_s && bank_ok_s && !full_sel_s;
  assign drop_s = hs_s && !(bank_ok_s && !full_sel_s);
`endif
  assign bank_inc_s = wr_s ? bank_oh_s : {N_BANKS{1'b0}};
  assign tohost_s   = MON_WE && (MON_ADDR == ADDR_W'(TOHOST_ADDR));

  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    prog_loader_bank_addr #(.ADDR_W(ADDR_W)) u_addr (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .clr_i  (clr_s),
      .inc_i  (bank_inc_s[g]),
      .addr_o (bank_addr_s[g]),
      .full_o (bank_full_s[g])
    );
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    pass_d      = pass_q;
    tout_d      = tout_q;
    err_d       = err_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    csum_d      = csum_q;
    csum_ok_d   = csum_ok_q;
    clr_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d   = ST_LOAD;
          clr_s     = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          tout_d    = 1'b0;
          err_d     = 1'b0;
          result_d  = '0;
          cycles_d  = '0;
          csum_d    = 32'd0;
          csum_ok_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (wr_s) begin
          mem_we_d    = bank_oh_s;
          mem_addr_d  = addr_sel_s;
          mem_wdata_d = LOAD_DATA;
          csum_d      = csum_q + 32'(LOAD_DATA);
        end else begin
          mem_we_d = '0;
        end
        err_d = err_q | drop_s;
        if (hs_s && LOAD_LAST) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (32'(LOAD_DATA) == csum_q) begin
            csum_ok_d = 1'b1;
            state_d   = ST_RELEASE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            state_d = ST_DONE;
          end
`else
          state_d = ST_RELEASE;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        cycles_d = cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        // Completion takes priority over a timeout landing in the same cycle
        if (tohost_s) begin
          result_d = MON_WDATA;
          pass_d   = (MON_WDATA == DATA_W'(PASS_CODE)) && !err_q;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (cycles_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tout_d  = 1'b1;
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
    crn_d   = (state_d == ST_RUN);
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      crn_q       <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tout_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      cycles_q    <= '0;
      csum_q      <= 32'd0;
      csum_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      crn_q       <= crn_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tout_q      <= tout_d;
      err_q       <= err_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      csum_q      <= csum_d;
      csum_ok_q   <= csum_ok_d;
    end
  end

  assign LOAD_READY   = ready_q;
  assign MEM_WE       = mem_we_q;
  assign MEM_ADDR     = mem_addr_q;
  assign MEM_WDATA    = mem_wdata_q;
  assign CORE_RESET_N = crn_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign PASS         = pass_q;
  assign TIMEOUT      = tout_q;
  assign LOAD_ERR     = err_q;
  assign RESULT       = result_q;
  assign CYCLES       = cycles_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign CSUM_OK      = csum_ok_q;
`endif

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Drives two controllers from one stimulus stream: A with default sizing, B with
// 4-deep banks and a 20-cycle timeout, each checked against a queue-based model.
module tb_prog_loader_ctrl;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0, mon_we = 1'b0;
  logic [31:0] load_data = 32'd0, mon_wdata = 32'd0;
  logic [0:0]  load_bank = 1'b0;
  logic [9:0]  mon_addr = 10'd0;

  logic        a_ready, a_crn, a_busy, a_done, a_pass, a_tout, a_err;
  logic [1:0]  a_we;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata, a_result, a_cycles;
  logic        b_ready, b_crn, b_busy, b_done, b_pass, b_tout, b_err;
  logic [1:0]  b_we;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_result, b_cycles;

  typedef struct packed {
    logic [1:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t obs_a[$], obs_b[$];
  int  n_checks = 0, n_fail = 0, run_cyc = 0;
  bit  err_exp[2];
  bit  b_running = 1'b0;

  prog_loader_ctrl u_dut_a (
    .CLK(clk), .RESET(rst), .START(start), .LOAD_VALID(load_valid), .LOAD_READY(a_ready),
    .LOAD_DATA(load_data), .LOAD_BANK(load_bank), .LOAD_LAST(load_last), .MEM_WE(a_we),
    .MEM_ADDR(a_addr), .MEM_WDATA(a_wdata), .CORE_RESET_N(a_crn), .MON_WE(mon_we),
    .MON_ADDR(mon_addr), .MON_WDATA(mon_wdata), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
    .TIMEOUT(a_tout), .LOAD_ERR(a_err), .RESULT(a_result), .CYCLES(a_cycles)
  );

  prog_loader_ctrl #(.ADDR_W(2), .TOHOST_ADDR(32'h3), .TIMEOUT_CYC(20)) u_dut_b (
    .CLK(clk), .RESET(rst), .START(start), .LOAD_VALID(load_valid), .LOAD_READY(b_ready),
    .LOAD_DATA(load_data), .LOAD_BANK(load_bank), .LOAD_LAST(load_last), .MEM_WE(b_we),
    .MEM_ADDR(b_addr), .MEM_WDATA(b_wdata), .CORE_RESET_N(b_crn), .MON_WE(mon_we),
    .MON_ADDR(mon_addr[1:0]), .MON_WDATA(mon_wdata), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
    .TIMEOUT(b_tout), .LOAD_ERR(b_err), .RESULT(b_result), .CYCLES(b_cycles)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample just after the edge and log any bank write pulse
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (a_we != 2'b00) begin
      w = {a_we, a_addr, a_wdata};
      obs_a.push_back(w);
    end
    if (b_we != 2'b00) begin
      w = {b_we, 8'd0, b_addr, b_wdata};
      obs_b.push_back(w);
    end
    run_cyc++;
  endtask

  // Random core stores that never hit tohost in either instance
  task automatic noise();
    mon_we    = 1'($urandom_range(0, 1));
    mon_addr  = {8'($urandom_range(0, 255)), 2'b00};
    mon_wdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if ({a_crn, a_busy, a_done, a_pass, a_tout, a_err, a_ready} !== 7'd0) begin
      n_fail++; $display("FAIL reset_a_flags: got %b want 0000000", {a_crn, a_busy, a_done, a_pass, a_tout, a_err, a_ready});
    end
    n_checks++;
    if ({a_result, a_cycles, a_we} !== 66'd0) begin
      n_fail++; $display("FAIL reset_a_words: got result=%h cycles=%0d we=%b want zeros", a_result, a_cycles, a_we);
    end
    n_checks++;
    if ({b_crn, b_busy, b_done, b_pass, b_tout, b_err, b_ready} !== 7'd0) begin
      n_fail++; $display("FAIL reset_b_flags: got %b want 0000000", {b_crn, b_busy, b_done, b_pass, b_tout, b_err, b_ready});
    end
    n_checks++;
    rst = 1'b0;
    tick();
  endtask

  // Start a load of nb0 words to bank 0 and nb1 to bank 1, then check every write
  task automatic test_load(input int nb0, input int nb1, input bit mix);
    int          banks[$];
    logic [31:0] datas[$];
    int          cnt[2];
    int          idx, depth, j, t, nobs;
    bit          err;
    wr_t         got, exp;
    for (int i = 0; i < nb0; i++) banks.push_back(0);
    for (int i = 0; i < nb1; i++) banks.push_back(1);
    if (mix) begin
      for (int i = banks.size() - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = banks[i]; banks[i] = banks[j]; banks[j] = t;
      end
    end
    for (int i = 0; i < banks.size(); i++) datas.push_back($urandom);
    obs_a.delete();
    obs_b.delete();
    mon_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if ({a_ready, b_ready, a_busy} !== 3'b111) begin
      n_fail++; $display("FAIL load_ready: got %b want 111", {a_ready, b_ready, a_busy});
    end
    n_checks++;
    for (int i = 0; i < banks.size(); i++) begin
      repeat ($urandom_range(0, 2)) tick();
      load_valid = 1'b1;
      load_bank  = 1'(banks[i]);
      load_data  = datas[i];
      load_last  = (i == banks.size() - 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
    if ({a_crn, b_crn, a_ready} !== 3'b000) begin
      n_fail++; $display("FAIL release_core_reset: got %b want 000", {a_crn, b_crn, a_ready});
    end
    n_checks++;
    tick();
    if ({a_crn, b_crn, a_busy, b_busy} !== 4'b1111) begin
      n_fail++; $display("FAIL run_core_reset: got %b want 1111", {a_crn, b_crn, a_busy, b_busy});
    end
    n_checks++;
    run_cyc   = 1;
    b_running = 1'b1;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? 1024 : 4;
      cnt[0] = 0; cnt[1] = 0; idx = 0; err = 1'b0;
      nobs = (d == 0) ? obs_a.size() : obs_b.size();
      for (int i = 0; i < banks.size(); i++) begin
        if (cnt[banks[i]] < depth) begin
          exp = {2'(1 << banks[i]), 10'(cnt[banks[i]]), datas[i]};
          if (idx >= nobs) got = '0;
          else if (d == 0) got = obs_a[idx];
          else got = obs_b[idx];
          if (got !== exp) begin
            n_fail++; $display("FAIL mem_write dut%0d #%0d: got %h want %h", d, idx, got, exp);
          end
          n_checks++;
          idx++;
        end else begin
          err = 1'b1;
        end
        cnt[banks[i]]++;
      end
      if (nobs != idx) begin
        n_fail++; $display("FAIL write_count dut%0d: got %0d want %0d", d, nobs, idx);
      end
      n_checks++;
      if (((d == 0) ? a_err : b_err) !== err) begin
        n_fail++; $display("FAIL load_err dut%0d: got %b want %b", d, (d == 0) ? a_err : b_err, err);
      end
      n_checks++;
      err_exp[d] = err;
    end
  endtask

  // Run with no tohost store until B's 20-cycle timeout fires
  task automatic test_timeout();
    while (run_cyc < 20) begin
      noise();
      tick();
    end
    mon_we = 1'b0;
    tick();
    if ({b_done, b_tout, b_pass, b_crn, b_busy} !== 5'b11000 || b_cycles !== 32'd20) begin
      n_fail++; $display("FAIL timeout_b: got dtpcb=%b cycles=%0d want 11000 cycles=20", {b_done, b_tout, b_pass, b_crn, b_busy}, b_cycles);
    end
    n_checks++;
    if ({a_done, a_crn} !== 2'b01 || a_cycles !== 32'd20) begin
      n_fail++; $display("FAIL still_running_a: got done/crn=%b cycles=%0d want 01 cycles=20", {a_done, a_crn}, a_cycles);
    end
    n_checks++;
    b_running = 1'b0;
  endtask

  // Store data to tohost on run cycle k and check the captured outcome
  task automatic test_complete(input int k, input logic [31:0] data);
    while (run_cyc < k) begin
      noise();
      tick();
    end
    mon_we = 1'b1; mon_addr = 10'h3FF; mon_wdata = data;
    tick();
    mon_we = 1'b0;
    if ({a_done, a_pass, a_tout, a_crn, a_busy} !== {2'b11 & {1'b1, (data == 32'd1) && !err_exp[0]}, 3'b000}) begin
      n_fail++; $display("FAIL complete_a_flags: got dptcb=%b want pass=%b", {a_done, a_pass, a_tout, a_crn, a_busy}, (data == 32'd1) && !err_exp[0]);
    end
    n_checks++;
    if (a_result !== data || a_cycles !== 32'(k)) begin
      n_fail++; $display("FAIL complete_a_words: got result=%h cycles=%0d want %h %0d", a_result, a_cycles, data, k);
    end
    n_checks++;
    if (b_running) begin
      if ({b_done, b_pass, b_tout} !== {1'b1, (data == 32'd1) && !err_exp[1], 1'b0} || b_result !== data || b_cycles !== 32'(k)) begin
        n_fail++; $display("FAIL complete_b: got dpt=%b result=%h cycles=%0d want pass=%b %h %0d", {b_done, b_pass, b_tout}, b_result, b_cycles, (data == 32'd1) && !err_exp[1], data, k);
      end
    end else begin
      if ({b_done, b_tout} !== 2'b11 || b_result !== 32'd0) begin
        n_fail++; $display("FAIL done_b_ignores_store: got dt=%b result=%h want 11 0", {b_done, b_tout}, b_result);
      end
    end
    n_checks++;
    b_running = 1'b0;
    noise();
    tick();
    mon_we = 1'b0;
    if (a_cycles !== 32'(k) || a_done !== 1'b1 || a_crn !== 1'b0) begin
      n_fail++; $display("FAIL done_hold_a: got cycles=%0d done=%b crn=%b want %0d 1 0", a_cycles, a_done, a_crn, k);
    end
    n_checks++;
  endtask

  // Reset mid-run clears everything; the next load restarts at address 0
  task automatic test_reset_mid_run();
    test_load(5, 0, 1'b0);
    while (run_cyc < 7) begin
      noise();
      tick();
    end
    rst = 1'b1;
    #2;
    if ({a_crn, a_busy, a_ready, b_err, b_busy} !== 5'd0 || a_cycles !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got crn/busy/rdy/berr/bbusy=%b cycles=%0d want 0", {a_crn, a_busy, a_ready, b_err, b_busy}, a_cycles);
    end
    n_checks++;
    tick();
    rst = 1'b0;
    mon_we = 1'b0;
    tick();
    test_load(2, 2, 1'b1);
    test_complete(12, ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom);
  endtask

  initial begin
    test_reset();
    test_load(4, 2, 1'b0);
    test_timeout();
    test_complete(50, 32'd1);
    test_load(3, 3, 1'b1);
    test_complete(20, 32'd1);
    test_load(4, 2, 1'b1);
    test_complete($urandom_range(5, 15), 32'h0000_0BAD);
    test_load(5, 0, 1'b0);
    test_complete(15, 32'd1);
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
Synthesizable program-load and run controller for the RISC-V pipeline top level. It replaces hard-coded memory preloading with a streamed load of N_BANKS memory images (e.g. instruction ROM, data RAM) over a valid/ready port. While loading, it holds the core in reset. It then releases the core, snoops core stores for a "tohost" completion write, and reports pass/fail, the result word and the cycle count, with a timeout guard.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 10, word address width per bank; bank depth = 2**ADDR_W
N_BANKS, 2, number of memory images (bank 0 = instruction, bank 1 = data)
TOHOST_ADDR, 10'h3FF, word address whose store ends the run
TIMEOUT_CYC, 100000, run cycles before timeout
CNT_W, 32, cycle counter width

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous reset, active-high
START  in  1  one-cycle pulse; begins load, honoured only in IDLE/DONE
LOAD_VALID  in  1  stream word valid
LOAD_READY  out  1  stream word accepted when VALID&READY
LOAD_DATA  in  DATA_W  word to write
LOAD_BANK  in  max(1,$clog2(N_BANKS))  target bank of word
LOAD_LAST  in  1  final word of whole image
MEM_WE  out  N_BANKS  one-hot bank write enable
MEM_ADDR  out  ADDR_W  write address
MEM_WDATA  out  DATA_W  write data
CORE_RESET_N  out  1  reset to core, active-low
MON_WE  in  1  core data-store strobe
MON_ADDR  in  ADDR_W  core store word address
MON_WDATA  in  DATA_W  core store data
BUSY  out  1  state is LOAD or RUN
DONE  out  1  run finished, sticky
PASS  out  1  valid with DONE
TIMEOUT  out  1  sticky timeout flag
LOAD_ERR  out  1  sticky: bank overflow or bad bank index
RESULT  out  DATA_W  captured tohost word
CYCLES  out  CNT_W  run cycles counted

Behaviour:
- Reset: state IDLE, all outputs 0 except CORE_RESET_N=0, per-bank address counters 0. Reset mid-load or mid-run aborts immediately, with no partial flags retained.
- FSM: IDLE -START-> LOAD -accepted LOAD_LAST-> RELEASE (1 cycle, CORE_RESET_N still 0) -> RUN -tohost store or timeout-> DONE -START-> LOAD.
- START clears DONE/PASS/TIMEOUT/LOAD_ERR/RESULT/CYCLES and all bank counters on the same edge. START in LOAD/RUN is ignored.
- LOAD: LOAD_READY=1. On each handshake, MEM_WE[bank], MEM_ADDR=addr[bank] and MEM_WDATA are registered, appearing 1 cycle after the handshake for exactly 1 cycle. addr[bank] then increments.
- LOAD boundary cases:
  - Word when addr[bank] is already at 2**ADDR_W-1 and written: the word is dropped, LOAD_ERR=1, the counter saturates (no wrap).
  - LOAD_BANK>=N_BANKS: the word is dropped and LOAD_ERR=1.
  - LOAD_LAST on a dropped word still ends the load.
- RUN: CORE_RESET_N=1 from the first RUN cycle. CYCLES increments every RUN cycle, including the terminating cycle.
- Completion: MON_WE && MON_ADDR==TOHOST_ADDR. RESULT=MON_WDATA, PASS=(MON_WDATA==1)&&!LOAD_ERR, DONE=1, next state DONE.
- Timeout: when CYCLES reaches TIMEOUT_CYC-1 and no completion occurs that cycle, TIMEOUT=1, DONE=1, PASS=0. If completion and timeout fall in the same cycle, completion wins.
- DONE state: CORE_RESET_N=0 (core frozen) and CYCLES held.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- When defined: a running 32-bit wrapping sum of accepted, non-dropped words is kept. The word flagged LOAD_LAST is not written; it is compared to the sum instead. On mismatch, LOAD_ERR=1, the FSM goes LOAD->DONE with PASS=0, and the core is never released. Output CSUM_OK (1 bit) is added.
- When not defined: the LAST word is an ordinary data word and no CSUM_OK port exists.

Decomposition:
- Package prog_loader_pkg holds the state enum (IDLE, LOAD, RELEASE, RUN, DONE) and the PASS_CODE constant (32'd1).
- One sub-module, prog_loader_bank_addr: per-bank saturating address counter with overflow flag, instantiated N_BANKS times by generate.

Test Plan:
- Load 4 words to bank 0 and 2 words to bank 1 (last flagged) -> MEM_WE pulses 6 times, bank 0 at addresses 0..3 and bank 1 at addresses 0..1; CORE_RESET_N rises 2 cycles after the LAST handshake.
- In RUN, drive MON_WE with addr 0x3FF, data 1 on run cycle 50 -> DONE=1, PASS=1, RESULT=1, CYCLES=50.
- Same as previous but data 0x0000_0BAD -> PASS=0, RESULT=0xBAD.
- TIMEOUT_CYC=20 with no store -> TIMEOUT=1, DONE=1, CYCLES=20, CORE_RESET_N back to 0.
- ADDR_W=2: send 5 words to bank 0 -> 4 writes, LOAD_ERR=1, later PASS=0 even when data 1 is stored.
- Assert RESET mid-RUN, then START -> all flags 0 and counters restart from address 0.
